// File: rtl/exu_alu_seq.sv
// Execute-side ALU: single-cycle add/compare/logic ops and an iterative 1-bit-per-cycle shifter,
// with a registered GPR writeback held under valid/ready backpressure.
module exu_alu_seq #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned GPR_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [GPR_AW-1:0] in_waddr,
  input  logic              in_wen,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [GPR_AW-1:0] wb_waddr,
  output logic [XLEN-1:0]   wb_wdata,
  output logic              wb_wen,
  output logic              wb_illegal,
  output logic              busy
);

  localparam logic [OPC_W-1:0] AluOpcAdd   = OPC_W'(0);
  localparam logic [OPC_W-1:0] AluOpcLessS = OPC_W'(1);
  localparam logic [OPC_W-1:0] AluOpcLessU = OPC_W'(2);
  localparam logic [OPC_W-1:0] AluOpcXor   = OPC_W'(3);
  localparam logic [OPC_W-1:0] AluOpcOr    = OPC_W'(4);
  localparam logic [OPC_W-1:0] AluOpcAnd   = OPC_W'(5);
  localparam logic [OPC_W-1:0] AluOpcSl    = OPC_W'(6);
  localparam logic [OPC_W-1:0] AluOpcSrl   = OPC_W'(7);
  localparam logic [OPC_W-1:0] AluOpcSra   = OPC_W'(8);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     acc_q, acc_d, acc_shifted;
  logic [4:0]          cnt_q, cnt_d;
  logic                dir_q, dir_d;      // 1: right shift
  logic                arith_q, arith_d;
  logic [GPR_AW-1:0]   sh_waddr_q, sh_waddr_d;
  logic                sh_wen_q, sh_wen_d;
  logic                wb_valid_q, wb_valid_d;
  logic [GPR_AW-1:0]   wb_waddr_q, wb_waddr_d;
  logic [XLEN-1:0]     wb_wdata_q, wb_wdata_d;
  logic                wb_wen_q, wb_wen_d;
  logic                wb_illegal_q, wb_illegal_d;

  logic                accept;
  logic                wen_eff;
  logic [4:0]          shamt;
  logic                is_shift;
  logic                illegal;
  logic [XLEN-1:0]     op_result;

  assign shamt    = in_src2[4:0];
  assign wen_eff  = in_wen && (in_waddr != '0);
  assign in_ready = (state_q == StIdle) && (!wb_valid_q || wb_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Single-cycle result; zero-amount shifts also resolve here.
  always_comb begin
    op_result = '0;
    is_shift  = 1'b0;
    illegal   = 1'b0;
    unique case (in_opcode)
      AluOpcAdd:   op_result = in_src1 + in_src2;
      AluOpcLessS: op_result = XLEN'($signed(in_src1) < $signed(in_src2));
      AluOpcLessU: op_result = XLEN'(in_src1 < in_src2);
      AluOpcXor:   op_result = in_src1 ^ in_src2;
      AluOpcOr:    op_result = in_src1 | in_src2;
      AluOpcAnd:   op_result = in_src1 & in_src2;
      AluOpcSl, AluOpcSrl, AluOpcSra: begin
        op_result = in_src1;
        is_shift  = 1'b1;
      end
      default:     illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    arith_d      = arith_q;
    sh_waddr_d   = sh_waddr_q;
    sh_wen_d     = sh_wen_q;
    wb_valid_d   = wb_valid_q;
    wb_waddr_d   = wb_waddr_q;
    wb_wdata_d   = wb_wdata_q;
    wb_wen_d     = wb_wen_q;
    wb_illegal_d = wb_illegal_q;
    acc_shifted  = dir_q ? {arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]}
                         : {acc_q[XLEN-2:0], 1'b0};

    if (wb_valid_q && wb_ready) wb_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_shift && (shamt != 5'd0)) begin
            state_d    = StShift;
            acc_d      = in_src1;
            cnt_d      = shamt;
            dir_d      = (in_opcode != AluOpcSl);
            arith_d    = (in_opcode == AluOpcSra);
            sh_waddr_d = in_waddr;
            sh_wen_d   = wen_eff;
          end else begin
            wb_valid_d   = 1'b1;
            wb_waddr_d   = in_waddr;
            wb_wdata_d   = op_result;
            wb_wen_d     = wen_eff && !illegal;
            wb_illegal_d = illegal;
          end
        end
      end
      StShift: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - 5'd1;
        // Output was drained at accept, so the register is free on completion.
        if (cnt_q == 5'd1) begin
          state_d      = StIdle;
          wb_valid_d   = 1'b1;
          wb_waddr_d   = sh_waddr_q;
          wb_wdata_d   = acc_shifted;
          wb_wen_d     = sh_wen_q;
          wb_illegal_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      wb_valid_d = 1'b0;
      state_d    = StIdle;
      cnt_d      = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      arith_q      <= 1'b0;
      sh_waddr_q   <= '0;
      sh_wen_q     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= '0;
      wb_wen_q     <= 1'b0;
      wb_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      arith_q      <= arith_d;
      sh_waddr_q   <= sh_waddr_d;
      sh_wen_q     <= sh_wen_d;
      wb_valid_q   <= wb_valid_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
      wb_wen_q     <= wb_wen_d;
      wb_illegal_q <= wb_illegal_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_waddr   = wb_waddr_q;
  assign wb_wdata   = wb_wdata_q;
  assign wb_wen     = wb_wen_q;
  assign wb_illegal = wb_illegal_q;
  assign busy       = (state_q != StIdle) || wb_valid_q;

endmodule
